// File: rtl/power_xo_exec_unit.sv
// Multi-cycle PowerISA integer execute unit with a private GPR file.
// One instruction in flight: IDLE -> EXEC -> (MUL) -> RESP -> IDLE.
module power_xo_exec_unit #(
    parameter int XLEN     = 32,
    parameter int NUM_GPR  = 32,
    parameter int MUL_BITS = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [XLEN-1:0] res_data,
    output logic [4:0]      res_rt,
    output logic            res_wen,
    output logic            res_illegal,
    output logic [3:0]      cr0,
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data
);
    localparam int AW   = (NUM_GPR > 1) ? $clog2(NUM_GPR) : 1;
    localparam int ITER = 32 / MUL_BITS;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_RESP} state_t;

    state_t          r_state;
    logic [31:0]     r_instr;
    logic [XLEN-1:0] r_gpr [NUM_GPR];
    logic [3:0]      r_cr0;
    logic            r_res_valid;
    logic [XLEN-1:0] r_res_data;
    logic [4:0]      r_res_rt;
    logic            r_res_wen;
    logic            r_res_illegal;
    // Multiplier state: the accumulator only needs XLEN bits because the
    // kept product is the low XLEN bits of the signed 32x32 product.
    logic [XLEN-1:0] r_acc;
    logic [XLEN-1:0] r_mcand;
    logic [31:0]     r_mplier;
    logic [CW-1:0]   r_cnt;

    // Instruction fields
    logic [5:0] w_opcd;
    logic [4:0] w_rt, w_ra, w_rb;
    logic [8:0] w_xo9;
    logic [9:0] w_xo10;
    logic       w_rc;
    assign w_opcd = r_instr[31:26];
    assign w_rt   = r_instr[25:21];
    assign w_ra   = r_instr[20:16];
    assign w_rb   = r_instr[15:11];
    assign w_xo9  = r_instr[9:1];
    assign w_xo10 = r_instr[10:1];
    assign w_rc   = r_instr[0];

    // Register reads; indices beyond the implemented file read as zero
    logic [XLEN-1:0] w_ra_val, w_rb_val, w_rs_val;
    assign w_ra_val = ({1'b0, w_ra} < 6'(NUM_GPR)) ? r_gpr[w_ra[AW-1:0]] : '0;
    assign w_rb_val = ({1'b0, w_rb} < 6'(NUM_GPR)) ? r_gpr[w_rb[AW-1:0]] : '0;
    assign w_rs_val = ({1'b0, w_rt} < 6'(NUM_GPR)) ? r_gpr[w_rt[AW-1:0]] : '0;
    assign dbg_data = ({1'b0, dbg_addr} < 6'(NUM_GPR)) ? r_gpr[dbg_addr[AW-1:0]] : '0;

    // Decode; X-form logicals match the full 10-bit XO, XO-form ignores OE
    logic w_is31, w_is_addi, w_is_and, w_is_or, w_is_xor;
    logic w_is_add, w_is_subf, w_is_mul, w_legal;
    assign w_is31    = (w_opcd == 6'd31);
    assign w_is_addi = (w_opcd == 6'd14);
    assign w_is_and  = w_is31 && (w_xo10 == 10'd28);
    assign w_is_or   = w_is31 && (w_xo10 == 10'd444);
    assign w_is_xor  = w_is31 && (w_xo10 == 10'd316);
    assign w_is_add  = w_is31 && (w_xo9 == 9'd266);
    assign w_is_subf = w_is31 && (w_xo9 == 9'd40);
    assign w_is_mul  = w_is31 && (w_xo9 == 9'd235);
    assign w_legal   = w_is_addi | w_is_and | w_is_or | w_is_xor |
                       w_is_add | w_is_subf | w_is_mul;

    // Single-cycle datapath: result, destination and whether CR0 updates
    logic [XLEN-1:0] w_alu;
    logic [4:0]      w_dst;
    logic            w_upd_cr;
    always_comb begin
        w_alu    = '0;
        w_dst    = w_rt;
        w_upd_cr = 1'b0;
        if (w_is_addi) begin
            w_alu = ((w_ra == 5'd0) ? '0 : w_ra_val) + XLEN'($signed(r_instr[15:0]));
        end else if (w_is_and || w_is_or || w_is_xor) begin
            w_dst    = w_ra;
            w_upd_cr = w_rc;
            if (w_is_and)     w_alu = w_rs_val & w_rb_val;
            else if (w_is_or) w_alu = w_rs_val | w_rb_val;
            else              w_alu = w_rs_val ^ w_rb_val;
        end else if (w_is_add) begin
            w_alu    = w_ra_val + w_rb_val;
            w_upd_cr = w_rc;
        end else if (w_is_subf) begin
            w_alu    = w_rb_val - w_ra_val;
            w_upd_cr = w_rc;
        end
    end

    logic w_dst_ok, w_wen;
    assign w_dst_ok = ({1'b0, w_dst} < 6'(NUM_GPR));
    assign w_wen    = w_legal && w_dst_ok;

    // Partial products for the MUL_BITS multiplier bits retired this cycle
    logic [XLEN-1:0] w_pp [MUL_BITS];
    generate
        for (genvar gi = 0; gi < MUL_BITS; gi++) begin : g_pp
            assign w_pp[gi] = r_mplier[gi] ? (r_mcand << gi) : '0;
        end
    endgenerate

    // Accumulate; multiplier bit 31 carries negative weight (signed operand)
    logic            w_last;
    logic [XLEN-1:0] w_acc_next;
    assign w_last = (r_cnt == CW'(ITER - 1));
    always_comb begin
        w_acc_next = r_acc;
        for (int j = 0; j < MUL_BITS; j++) begin
            if (w_last && (j == MUL_BITS - 1)) w_acc_next = w_acc_next - w_pp[j];
            else                               w_acc_next = w_acc_next + w_pp[j];
        end
    end

    function automatic logic [3:0] cr_of(input logic [XLEN-1:0] v);
        return {v[XLEN-1], ~v[XLEN-1] & (|v), ~(|v), 1'b0};
    endfunction

    // Control FSM, register file, CR0 and registered result outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_instr       <= '0;
            r_cr0         <= '0;
            r_res_valid   <= 1'b0;
            r_res_data    <= '0;
            r_res_rt      <= '0;
            r_res_wen     <= 1'b0;
            r_res_illegal <= 1'b0;
            r_acc         <= '0;
            r_mcand       <= '0;
            r_mplier      <= '0;
            r_cnt         <= '0;
            for (int i = 0; i < NUM_GPR; i++) r_gpr[i] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_instr <= instruction;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (w_is_mul) begin
                        r_acc    <= '0;
                        r_mcand  <= XLEN'($signed(w_ra_val[31:0]));
                        r_mplier <= w_rb_val[31:0];
                        r_cnt    <= '0;
                        r_state  <= S_MUL;
                    end else begin
                        r_res_valid   <= 1'b1;
                        r_res_data    <= w_alu;
                        r_res_rt      <= w_dst;
                        r_res_wen     <= w_wen;
                        r_res_illegal <= ~w_legal;
                        if (w_wen) r_gpr[w_dst[AW-1:0]] <= w_alu;
                        if (w_legal && w_upd_cr) r_cr0 <= cr_of(w_alu);
                        r_state <= S_RESP;
                    end
                end
                S_MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << MUL_BITS;
                    r_mplier <= r_mplier >> MUL_BITS;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_res_valid   <= 1'b1;
                        r_res_data    <= w_acc_next;
                        r_res_rt      <= w_rt;
                        r_res_wen     <= w_dst_ok;
                        r_res_illegal <= 1'b0;
                        if (w_dst_ok) r_gpr[w_rt[AW-1:0]] <= w_acc_next;
                        if (w_rc) r_cr0 <= cr_of(w_acc_next);
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready    = (r_state == S_IDLE);
    assign res_valid   = r_res_valid;
    assign res_data    = r_res_data;
    assign res_rt      = r_res_rt;
    assign res_wen     = r_res_wen;
    assign res_illegal = r_res_illegal;
    assign cr0         = r_cr0;
endmodule
